uart_rx_sampler: RTL and testbench
==================================

UART_RX_SAMPLER -- requirements
Module: uart_rx_sampler

Interface
REQ-001 SHALL have parameter PRESCALE_W, default 6, width of the Prescale port.
REQ-002 SHALL have ports: CLK  in  1  receive clock (oversampling rate).
REQ-003 RSTn  in  1  asynchronous active-low reset.
REQ-004 RX_IN  in  1  serial line, idle high.
REQ-005 Prescale  in  PRESCALE_W  oversampling ratio; legal values 8, 16, 32.
REQ-006 Counter_En  in  1  from rx FSM; enables edge/bit counting.
REQ-007 New_Fram  in  1  from rx FSM; one-cycle pulse restarting the frame timebase.
REQ-008 Edge_Count  out  PRESCALE_W  oversample position within the current bit.
REQ-009 Bit_Counter  out  4  count of bits sampled in the current frame.
REQ-010 Sampled_Bit  out  1  majority-voted bit value.
REQ-011 Out_Valid  out  1  one-cycle pulse: Sampled_Bit and Bit_Counter are fresh.

Function
REQ-012 SHALL latch Prescale into an internal register on New_Fram; the latched value (Pl) governs the whole frame.
- Illegal Prescale (not 8/16/32) latches as 16.
REQ-013 On New_Fram: Edge_Count<=1, Bit_Counter<=0, vote registers cleared; New_Fram overrides every other condition in that cycle.
REQ-014 With Counter_En=1 and no New_Fram: Edge_Count increments each cycle; at Pl-1 it wraps to 0.
REQ-015 With Counter_En=0 and no New_Fram: Edge_Count<=0, Bit_Counter<=0, Out_Valid<=0; Sampled_Bit holds.
REQ-016 SHALL capture the line at Edge_Count = Pl/2-1, Pl/2 and Pl/2+1.
REQ-017 In the cycle Edge_Count = Pl/2+1, SHALL register:
- Sampled_Bit <= 2-of-3 majority of the three captures.
- Bit_Counter <= Bit_Counter+1.
- Out_Valid <= 1.
All three are visible on the next cycle (1-cycle latency from the third capture).
REQ-018 Out_Valid SHALL be high for exactly one cycle per bit; otherwise 0.
REQ-019 Frame bit numbering SHALL be: start bit = 1, data = 2..9, parity = 10 (if used), stop = 10 or 11.
REQ-020 Bit_Counter SHALL saturate at 15 and never wrap.
REQ-021 Prescale changes between New_Fram pulses SHALL have no effect.

Reset
REQ-022 On RSTn low, asynchronously:
- Edge_Count=0, Bit_Counter=0, Out_Valid=0, Sampled_Bit=1.
- Latched prescale=16.
- Synchronizer flops=1.
REQ-023 Reset asserted mid-frame SHALL abort the frame; no Out_Valid until the next New_Fram with Counter_En.

Configuration
REQ-024 With UART_RX_IN_SYNC_EN defined:
- RX_IN passes through a 2-flop synchronizer (reset to 1) before capture.
- All capture points lag the line by 2 cycles.
REQ-025 Without UART_RX_IN_SYNC_EN, RX_IN feeds capture directly; timing is as in REQ-016/017.

Structure
REQ-026 Shared package uart_rx_pkg SHALL hold:
- Prescale constants (8/16/32) and the default prescale of 16.
- Frame bit-number constants (start=1, last data=9, parity=10, stop=10/11).
REQ-027 Sub-module uart_rx_sync (2-flop synchronizer) SHALL be instantiated only under UART_RX_IN_SYNC_EN.

Verification
REQ-028 Pl=8, RX_IN held low, New_Fram then Counter_En: Out_Valid pulses 1 cycle after Edge_Count=5; Sampled_Bit=0; Bit_Counter=1.
REQ-029 Pl=16, frame 0x A5 (LSB first, no parity): 10 Out_Valid pulses, 16 cycles apart; bits 2..9 read 1,0,1,0,0,1,0,1; bit 10 reads 1.
REQ-030 Pl=16, one-cycle glitch at Edge_Count=8 inverting a '1' bit: Sampled_Bit=1 (majority holds).
REQ-031 Prescale switched 16->8 mid-frame: spacing stays 16 cycles until the next New_Fram, then becomes 8; Prescale=5 at New_Fram gives 16-cycle spacing.
REQ-032 Counter_En dropped at Bit_Counter=4: next cycle Bit_Counter=0, Edge_Count=0, no Out_Valid; RSTn pulse mid-bit gives all reset values immediately.
REQ-033 New_Fram coincident with Edge_Count=Pl/2+1: no Out_Valid next cycle; Bit_Counter=0, Edge_Count=1.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_pkg
// Shared constants and helpers for the UART receive path.
//   - Supported oversampling ratios (8/16/32) and the fallback ratio of 16.
//   - Frame bit numbers as counted by the sampler's Bit_Counter
//     (start bit is 1, data bits are 2..9, parity 10, stop 10 or 11).
//   - Bit_Counter saturation value.
//   - 2-of-3 majority vote helper.
// -----------------------------------------------------------------------------
package uart_rx_pkg;

  // Legal oversampling ratios and the value used when Prescale is illegal
  localparam int PRESCALE_8       = 8;
  localparam int PRESCALE_16      = 16;
  localparam int PRESCALE_32      = 32;
  localparam int PRESCALE_DEFAULT = PRESCALE_16;

  // Frame bit numbering seen on Bit_Counter
  localparam int BIT_START       = 1;
  localparam int BIT_FIRST_DATA  = 2;
  localparam int BIT_LAST_DATA   = 9;
  localparam int BIT_PARITY      = 10;
  localparam int BIT_STOP_NO_PAR = 10;
  localparam int BIT_STOP_PAR    = 11;

  // Bit_Counter is 4 bits wide and holds at this value instead of wrapping
  localparam int BIT_COUNT_W   = 4;
  localparam int BIT_COUNT_MAX = 15;

  typedef logic [BIT_COUNT_W-1:0] bit_cnt_t;

  // Two-of-three majority used to reject a single-sample glitch
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage : uart_rx_pkg

// File: rtl/uart_rx_sampler_if.sv
// -----------------------------------------------------------------------------
// uart_rx_sampler_if
// Control/status bundle between the receive FSM and the bit sampler.
//   Prescale    : oversampling ratio requested for the next frame
//   Counter_En  : FSM enables edge/bit counting
//   New_Fram    : one-cycle pulse restarting the frame timebase
//   Edge_Count  : oversample position within the current bit
//   Bit_Counter : number of bits sampled in the current frame
//   Sampled_Bit : majority-voted bit value
//   Out_Valid   : one-cycle pulse, Sampled_Bit/Bit_Counter are fresh
// Modports:
//   master : receive FSM side (drives Prescale/Counter_En/New_Fram)
//   slave  : sampler side (drives the counters and the sampled bit)
// -----------------------------------------------------------------------------
interface uart_rx_sampler_if #(
  parameter int PRESCALE_W = 6
) ();

  logic [PRESCALE_W-1:0] Prescale;
  logic                  Counter_En;
  logic                  New_Fram;
  logic [PRESCALE_W-1:0] Edge_Count;
  logic [3:0]            Bit_Counter;
  logic                  Sampled_Bit;
  logic                  Out_Valid;

  modport master (
    output Prescale,
    output Counter_En,
    output New_Fram,
    input  Edge_Count,
    input  Bit_Counter,
    input  Sampled_Bit,
    input  Out_Valid
  );

  modport slave (
    input  Prescale,
    input  Counter_En,
    input  New_Fram,
    output Edge_Count,
    output Bit_Counter,
    output Sampled_Bit,
    output Out_Valid
  );

endinterface : uart_rx_sampler_if

// File: rtl/uart_rx_sync.sv
// -----------------------------------------------------------------------------
// uart_rx_sync
// Two-flop synchronizer for the asynchronous serial line. Both flops reset to
// 1 (line idle) so that leaving reset never looks like a start-bit edge.
// The module only exists in builds with UART_RX_IN_SYNC_EN defined, which is
// the only configuration that instantiates it.
// Ports:
//   CLK      : receive clock
//   RSTn     : asynchronous active-low reset
//   rx_async : raw serial line
//   rx_sync  : line delayed by two clocks, safe to sample
// -----------------------------------------------------------------------------
`ifdef UART_RX_IN_SYNC_EN
module uart_rx_sync (
  input  logic CLK,
  input  logic RSTn,
  input  logic rx_async,
  output logic rx_sync
);

  logic meta_r;
  logic sync_r;

  // Two-stage capture of the asynchronous line, idle-high after reset
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      meta_r <= 1'b1;
      sync_r <= 1'b1;
    end else begin
      meta_r <= rx_async;
      sync_r <= meta_r;
    end
  end

  assign rx_sync = sync_r;

endmodule : uart_rx_sync
`endif

// File: rtl/uart_rx_sampler.sv
// -----------------------------------------------------------------------------
// uart_rx_sampler
// Oversampling bit sampler for a UART receiver. Counts oversample edges inside
// each bit, captures the line three times around the bit centre
// (Pl/2-1, Pl/2, Pl/2+1), majority-votes the captures and reports the result
// with a one-cycle Out_Valid pulse together with the running bit number.
// The oversampling ratio (Pl) is latched on New_Fram and holds for the whole
// frame; an unsupported ratio falls back to 16.
//
// Ports:
//   CLK    : receive clock (oversampling rate)
//   RSTn   : asynchronous active-low reset
//   RX_IN  : serial line, idle high
//   bus    : uart_rx_sampler_if.slave (Prescale, Counter_En, New_Fram in;
//            Edge_Count, Bit_Counter, Sampled_Bit, Out_Valid out)
//
// Build option:
//   UART_RX_IN_SYNC_EN : route RX_IN through a 2-flop synchronizer
//                        (uart_rx_sync) before capture; every capture then
//                        sees the line as it was two clocks earlier.
// -----------------------------------------------------------------------------
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = 6
) (
  input  logic               CLK,
  input  logic               RSTn,
  input  logic               RX_IN,
  uart_rx_sampler_if.slave   bus
);

  // Line value seen by the capture points
  logic rx_cap_s;

`ifdef UART_RX_IN_SYNC_EN
  uart_rx_sync u_rx_sync (
    .CLK      (CLK),
    .RSTn     (RSTn),
    .rx_async (RX_IN),
    .rx_sync  (rx_cap_s)
  );
`else
  assign rx_cap_s = RX_IN;
`endif

  // Frame state
  logic [PRESCALE_W-1:0] pl_r;        // prescale latched at New_Fram
  logic [PRESCALE_W-1:0] edge_cnt_r;
  bit_cnt_t              bit_cnt_r;
  logic                  sampled_r;
  logic                  valid_r;
  logic                  vote_lo_r;   // capture at Pl/2-1
  logic                  vote_mid_r;  // capture at Pl/2
  // Set by New_Fram, cleared by reset: a frame aborted by reset stays silent
  // until the FSM starts a new one.
  logic                  armed_r;

  // Derived timing points
  logic [PRESCALE_W-1:0] pl_next_s;
  logic [PRESCALE_W-1:0] cap_mid_s;
  logic [PRESCALE_W-1:0] cap_lo_s;
  logic [PRESCALE_W-1:0] cap_hi_s;
  logic [PRESCALE_W-1:0] edge_wrap_s;
  logic [PRESCALE_W-1:0] edge_next_s;
  bit_cnt_t              bit_cnt_inc_s;
  logic                  counting_s;

  // Sanitise the requested prescale; only 8/16/32 are accepted
  always_comb begin
    pl_next_s = PRESCALE_W'(PRESCALE_DEFAULT);
    case (bus.Prescale)
      PRESCALE_W'(PRESCALE_8),
      PRESCALE_W'(PRESCALE_16),
      PRESCALE_W'(PRESCALE_32): pl_next_s = bus.Prescale;
      default:                  pl_next_s = PRESCALE_W'(PRESCALE_DEFAULT);
    endcase
  end

  // Capture points, edge wrap and saturating bit increment for the latched Pl
  always_comb begin
    cap_mid_s   = pl_r >> 1;
    cap_lo_s    = cap_mid_s - PRESCALE_W'(1);
    cap_hi_s    = cap_mid_s + PRESCALE_W'(1);
    edge_wrap_s = pl_r - PRESCALE_W'(1);
    if (edge_cnt_r == edge_wrap_s) begin
      edge_next_s = {PRESCALE_W{1'b0}};
    end else begin
      edge_next_s = edge_cnt_r + PRESCALE_W'(1);
    end
    if (bit_cnt_r == bit_cnt_t'(BIT_COUNT_MAX)) begin
      bit_cnt_inc_s = bit_cnt_r;
    end else begin
      bit_cnt_inc_s = bit_cnt_r + 4'd1;
    end
    counting_s = bus.Counter_En & armed_r;
  end

  // Frame timebase, capture/vote and output registers
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      pl_r       <= PRESCALE_W'(PRESCALE_DEFAULT);
      edge_cnt_r <= {PRESCALE_W{1'b0}};
      bit_cnt_r  <= 4'd0;
      sampled_r  <= 1'b1;
      valid_r    <= 1'b0;
      vote_lo_r  <= 1'b0;
      vote_mid_r <= 1'b0;
      armed_r    <= 1'b0;
    end else if (bus.New_Fram) begin
      // New_Fram wins over counting, voting and output in the same cycle
      pl_r       <= pl_next_s;
      edge_cnt_r <= PRESCALE_W'(1);
      bit_cnt_r  <= 4'd0;
      valid_r    <= 1'b0;
      vote_lo_r  <= 1'b0;
      vote_mid_r <= 1'b0;
      armed_r    <= 1'b1;
    end else if (counting_s) begin
      edge_cnt_r <= edge_next_s;
      if (edge_cnt_r == cap_lo_s) begin
        vote_lo_r <= rx_cap_s;
      end
      if (edge_cnt_r == cap_mid_s) begin
        vote_mid_r <= rx_cap_s;
      end
      // Third capture is voted directly, result appears next cycle
      if (edge_cnt_r == cap_hi_s) begin
        sampled_r <= majority3(vote_lo_r, vote_mid_r, rx_cap_s);
        bit_cnt_r <= bit_cnt_inc_s;
        valid_r   <= 1'b1;
      end else begin
        valid_r   <= 1'b0;
      end
    end else begin
      // Idle: counters parked, last sampled bit kept for the FSM
      edge_cnt_r <= {PRESCALE_W{1'b0}};
      bit_cnt_r  <= 4'd0;
      valid_r    <= 1'b0;
    end
  end

  assign bus.Edge_Count  = edge_cnt_r;
  assign bus.Bit_Counter = bit_cnt_r;
  assign bus.Sampled_Bit = sampled_r;
  assign bus.Out_Valid   = valid_r;

endmodule : uart_rx_sampler

// File: tb/tb_uart_rx_sampler.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_sampler
// Self-checking bench for uart_rx_sampler. Stimulus tasks push the expected
// (Sampled_Bit, Bit_Counter) of every bit they drive into a scoreboard queue;
// a monitor pops and compares on each Out_Valid and records pulse times so the
// scenario tasks can check pulse spacing and counts.
// -----------------------------------------------------------------------------
module tb_uart_rx_sampler;

  localparam int PW = 6;

  typedef struct packed {
    logic       sb;
    logic [3:0] bc;
  } exp_t;

  logic clk;
  logic rst_n;
  logic rx_in;

  int   tests_run;
  int   tests_failed;
  int   cyc;
  exp_t sb_q[$];
  int   ov_times[$];

  uart_rx_sampler_if #(.PRESCALE_W(PW)) bus ();

  uart_rx_sampler #(.PRESCALE_W(PW)) dut (
    .CLK   (clk),
    .RSTn  (rst_n),
    .RX_IN (rx_in),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every Out_Valid must match the oldest expectation
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && bus.Out_Valid === 1'b1) begin
      ov_times.push_back(cyc);
      tests_run = tests_run + 1;
      if (sb_q.size() == 0) begin
        tests_failed = tests_failed + 1;
        $display("FAIL unexpected_valid: got Out_Valid=1 at cycle %0d, required no pulse", cyc);
      end else begin
        e = sb_q.pop_front();
        if (bus.Sampled_Bit !== e.sb || bus.Bit_Counter !== e.bc) begin
          tests_failed = tests_failed + 1;
          $display("FAIL bit_sample: got bit=%b cnt=%0d, required bit=%b cnt=%0d",
                   bus.Sampled_Bit, bus.Bit_Counter, e.sb, e.bc);
        end
      end
    end
  end

  // Drive one bit period; inv flips the line at the given oversample offsets.
  // Pushes the majority of the line at Pl/2-1..Pl/2+1 when push is set.
  task automatic drive_bit(input logic v, input logic [31:0] inv, input int len,
                           input int pl_eff, input bit nf, input bit push,
                           input logic [3:0] bc);
    exp_t e;
    int   ones;
    ones = 0;
    for (int k = pl_eff / 2 - 1; k <= pl_eff / 2 + 1; k++) begin
      if ((v ^ inv[k]) == 1'b1) ones++;
    end
    e.sb = (ones >= 2) ? 1'b1 : 1'b0;
    e.bc = bc;
    if (push) sb_q.push_back(e);
    for (int c = 0; c < len; c++) begin
      rx_in          = v ^ inv[c];
      bus.New_Fram   = (nf && c == 0) ? 1'b1 : 1'b0;
      bus.Counter_En = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.New_Fram = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.Counter_En = 1'b0;
    bus.New_Fram   = 1'b0;
    rx_in          = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    tests_run = tests_run + 4;
    if (bus.Edge_Count !== 6'd0) begin
      tests_failed++; $display("FAIL reset_edge: got %0d, required 0", bus.Edge_Count);
    end
    if (bus.Bit_Counter !== 4'd0) begin
      tests_failed++; $display("FAIL reset_bitcnt: got %0d, required 0", bus.Bit_Counter);
    end
    if (bus.Out_Valid !== 1'b0) begin
      tests_failed++; $display("FAIL reset_valid: got %b, required 0", bus.Out_Valid);
    end
    if (bus.Sampled_Bit !== 1'b1) begin
      tests_failed++; $display("FAIL reset_sampled: got %b, required 1", bus.Sampled_Bit);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Pl=8, line low: valid one cycle after Edge_Count=5, then low again
  task automatic test_single_bit_pl8();
    exp_t e;
    bus.Prescale   = 6'd8;
    rx_in          = 1'b0;
    bus.New_Fram   = 1'b1;
    bus.Counter_En = 1'b0;
    e.sb = 1'b0; e.bc = 4'd1;
    sb_q.push_back(e);
    @(posedge clk); #1;
    bus.New_Fram   = 1'b0;
    bus.Counter_En = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    tests_run = tests_run + 2;
    if (bus.Edge_Count !== 6'd5) begin
      tests_failed++; $display("FAIL pl8_edge5: got %0d, required 5", bus.Edge_Count);
    end
    if (bus.Out_Valid !== 1'b0) begin
      tests_failed++; $display("FAIL pl8_early_valid: got %b, required 0", bus.Out_Valid);
    end
    @(negedge clk);
    tests_run = tests_run + 2;
    if (bus.Out_Valid !== 1'b1) begin
      tests_failed++; $display("FAIL pl8_valid: got %b, required 1", bus.Out_Valid);
    end
    if (bus.Edge_Count !== 6'd6) begin
      tests_failed++; $display("FAIL pl8_edge6: got %0d, required 6", bus.Edge_Count);
    end
    @(negedge clk);
    tests_run = tests_run + 1;
    if (bus.Out_Valid !== 1'b0) begin
      tests_failed++; $display("FAIL pl8_one_cycle: got %b, required 0", bus.Out_Valid);
    end
    @(posedge clk); #1;
    idle(4);
  endtask

  task automatic check_gaps(input string name, input int n, input int gap);
    tests_run++;
    if (ov_times.size() != n) begin
      tests_failed++;
      $display("FAIL %s_count: got %0d pulses, required %0d", name, ov_times.size(), n);
    end
    for (int i = 1; i < ov_times.size(); i++) begin
      tests_run++;
      if (ov_times[i] - ov_times[i-1] != gap) begin
        tests_failed++;
        $display("FAIL %s_gap: got %0d cycles, required %0d", name, ov_times[i] - ov_times[i-1], gap);
      end
    end
  endtask

  // Pl=16, 0xA5 frame LSB first, no parity
  task automatic test_frame_a5();
    logic [9:0] fr;
    fr = {1'b1, 8'hA5, 1'b0};
    ov_times.delete();
    bus.Prescale = 6'd16;
    for (int i = 0; i < 10; i++)
      drive_bit(fr[i], 32'd0, 16, 16, (i == 0), 1'b1, 4'(i + 1));
    check_gaps("a5", 10, 16);
    idle(4);
  endtask

  // Pl=16 glitches: single flip is voted out, double flip wins
  task automatic test_glitch();
    bus.Prescale = 6'd16;
    drive_bit(1'b0, 32'd0, 16, 16, 1'b1, 1'b1, 4'd1);
    drive_bit(1'b1, 32'h0000_0100, 16, 16, 1'b0, 1'b1, 4'd2);
    tests_run++;
    if (bus.Sampled_Bit !== 1'b1) begin
      tests_failed++; $display("FAIL glitch_hold: got %b, required 1", bus.Sampled_Bit);
    end
    drive_bit(1'b1, 32'h0000_0180, 16, 16, 1'b0, 1'b1, 4'd3);
    drive_bit(1'b0, 32'h0000_0200, 16, 16, 1'b0, 1'b1, 4'd4);
    drive_bit(1'b1, 32'h0000_0280, 16, 16, 1'b0, 1'b1, 4'd5);
    drive_bit(1'b0, 32'h0000_0440, 16, 16, 1'b0, 1'b1, 4'd6);
    idle(4);
  endtask

  // Pl=8, 17 bits: counter climbs to 15 and holds
  task automatic test_saturation();
    logic v;
    ov_times.delete();
    bus.Prescale = 6'd8;
    for (int i = 1; i <= 17; i++) begin
      v = 1'($urandom_range(0, 1));
      drive_bit(v, 32'd0, 8, 8, (i == 1), 1'b1, (i > 15) ? 4'd15 : 4'(i));
    end
    check_gaps("sat", 17, 8);
    idle(4);
  endtask

  // Prescale only takes effect at New_Fram; illegal value falls back to 16
  task automatic test_prescale_latch();
    ov_times.delete();
    bus.Prescale = 6'd16;
    drive_bit(1'b0, 32'd0, 16, 16, 1'b1, 1'b1, 4'd1);
    bus.Prescale = 6'd8;
    drive_bit(1'b1, 32'd0, 16, 16, 1'b0, 1'b1, 4'd2);
    drive_bit(1'b0, 32'd0, 16, 16, 1'b0, 1'b1, 4'd3);
    check_gaps("ps_mid", 3, 16);
    idle(4);
    ov_times.delete();
    for (int i = 1; i <= 3; i++)
      drive_bit(i[0], 32'd0, 8, 8, (i == 1), 1'b1, 4'(i));
    check_gaps("ps_8", 3, 8);
    idle(4);
    ov_times.delete();
    bus.Prescale = 6'd5;
    for (int i = 1; i <= 3; i++)
      drive_bit(~i[0], 32'd0, 16, 16, (i == 1), 1'b1, 4'(i));
    check_gaps("ps_bad", 3, 16);
    idle(4);
  endtask

  // Counter_En drop after bit 4, then async reset in the middle of a bit
  task automatic test_counter_drop_and_reset();
    bus.Prescale = 6'd16;
    drive_bit(1'b0, 32'd0, 16, 16, 1'b1, 1'b1, 4'd1);
    drive_bit(1'b1, 32'd0, 16, 16, 1'b0, 1'b1, 4'd2);
    drive_bit(1'b0, 32'd0, 16, 16, 1'b0, 1'b1, 4'd3);
    drive_bit(1'b1, 32'd0, 12, 16, 1'b0, 1'b1, 4'd4);
    @(negedge clk);
    tests_run = tests_run + 2;
    if (bus.Bit_Counter !== 4'd4) begin
      tests_failed++; $display("FAIL drop_pre_cnt: got %0d, required 4", bus.Bit_Counter);
    end
    if (bus.Edge_Count !== 6'd12) begin
      tests_failed++; $display("FAIL drop_pre_edge: got %0d, required 12", bus.Edge_Count);
    end
    bus.Counter_En = 1'b0;
    @(negedge clk);
    tests_run = tests_run + 4;
    if (bus.Bit_Counter !== 4'd0) begin
      tests_failed++; $display("FAIL drop_cnt: got %0d, required 0", bus.Bit_Counter);
    end
    if (bus.Edge_Count !== 6'd0) begin
      tests_failed++; $display("FAIL drop_edge: got %0d, required 0", bus.Edge_Count);
    end
    if (bus.Out_Valid !== 1'b0) begin
      tests_failed++; $display("FAIL drop_valid: got %b, required 0", bus.Out_Valid);
    end
    if (bus.Sampled_Bit !== 1'b1) begin
      tests_failed++; $display("FAIL drop_hold: got %b, required 1", bus.Sampled_Bit);
    end
    @(posedge clk); #1;
    idle(2);
    drive_bit(1'b0, 32'd0, 16, 16, 1'b1, 1'b1, 4'd1);
    drive_bit(1'b1, 32'd0, 5, 16, 1'b0, 1'b0, 4'd2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests_run = tests_run + 4;
    if (bus.Edge_Count !== 6'd0) begin
      tests_failed++; $display("FAIL rst_mid_edge: got %0d, required 0", bus.Edge_Count);
    end
    if (bus.Bit_Counter !== 4'd0) begin
      tests_failed++; $display("FAIL rst_mid_cnt: got %0d, required 0", bus.Bit_Counter);
    end
    if (bus.Out_Valid !== 1'b0) begin
      tests_failed++; $display("FAIL rst_mid_valid: got %b, required 0", bus.Out_Valid);
    end
    if (bus.Sampled_Bit !== 1'b1) begin
      tests_failed++; $display("FAIL rst_mid_sampled: got %b, required 1", bus.Sampled_Bit);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ov_times.delete();
    rx_in          = 1'b0;
    bus.Counter_En = 1'b1;
    bus.New_Fram   = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    tests_run = tests_run + 2;
    if (ov_times.size() != 0) begin
      tests_failed++; $display("FAIL rst_abort: got %0d pulses, required 0", ov_times.size());
    end
    if (bus.Edge_Count !== 6'd0) begin
      tests_failed++; $display("FAIL rst_abort_edge: got %0d, required 0", bus.Edge_Count);
    end
    @(posedge clk); #1;
    idle(4);
  endtask

  // New_Fram in the cycle of the third capture suppresses the pulse
  task automatic test_new_fram_collision();
    bus.Prescale = 6'd16;
    drive_bit(1'b0, 32'd0, 16, 16, 1'b1, 1'b1, 4'd1);
    drive_bit(1'b1, 32'd0, 9, 16, 1'b0, 1'b0, 4'd2);
    @(negedge clk);
    tests_run++;
    if (bus.Edge_Count !== 6'd9) begin
      tests_failed++; $display("FAIL coll_pre_edge: got %0d, required 9", bus.Edge_Count);
    end
    bus.New_Fram = 1'b1;
    @(negedge clk);
    tests_run = tests_run + 3;
    if (bus.Out_Valid !== 1'b0) begin
      tests_failed++; $display("FAIL coll_valid: got %b, required 0", bus.Out_Valid);
    end
    if (bus.Bit_Counter !== 4'd0) begin
      tests_failed++; $display("FAIL coll_cnt: got %0d, required 0", bus.Bit_Counter);
    end
    if (bus.Edge_Count !== 6'd1) begin
      tests_failed++; $display("FAIL coll_edge: got %0d, required 1", bus.Edge_Count);
    end
    bus.New_Fram = 1'b0;
    @(posedge clk); #1;
    idle(4);
  endtask

  initial begin
    tests_run      = 0;
    tests_failed   = 0;
    cyc            = 0;
    rx_in          = 1'b1;
    bus.Prescale   = 6'd16;
    bus.Counter_En = 1'b0;
    bus.New_Fram   = 1'b0;
    test_reset();
    test_single_bit_pl8();
    test_frame_a5();
    test_glitch();
    test_saturation();
    test_prescale_latch();
    test_counter_drop_and_reset();
    test_new_fram_collision();
    tests_run++;
    if (sb_q.size() != 0) begin
      tests_failed++;
      $display("FAIL missing_valid: got %0d bits never reported, required 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_uart_rx_sampler
